// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: prefetches 32-pixel scanout words ahead of the beam and gives
// every other RAM slot to the CPU. Optional page flipping under FB_DOUBLE_BUFFER_EN.
module vga_fb_arbiter #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned FETCH_LEAD = 8,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
`ifdef FB_DOUBLE_BUFFER_EN
  ,
  parameter int unsigned PAGE_WORDS = 9600
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vga_h,
  input  logic [10:0] vga_v,
`ifdef FB_DOUBLE_BUFFER_EN
  input  logic        page_sel,
`endif
  output logic [31:0] vid_word,
  output logic        underrun,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle, StVidRd, StVidData, StCpuWr, StCpuRd, StCpuData
  } state_e;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] shadow_q, shadow_d;
  logic        shadow_valid_q, shadow_valid_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [31:0] vid_word_q, vid_word_d;
  logic        underrun_q, underrun_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [11:0] h_ext, hn;
  logic [10:0] tline;
  logic        trigger, reload, boundary;
  logic [15:0] reload_addr, fetch_addr;

  // Look FETCH_LEAD clocks ahead, wrapping into the next line (and frame) when needed.
  always_comb begin
    h_ext = {1'b0, vga_h} + 12'(FETCH_LEAD);
    hn    = h_ext;
    tline = vga_v;
    if (h_ext >= 12'(H_TOTAL)) begin
      hn    = h_ext - 12'(H_TOTAL);
      tline = (vga_v == 11'(V_TOTAL - 1)) ? 11'd0 : vga_v + 11'd1;
    end
    trigger  = (hn[4:0] == 5'd0) && (hn < 12'(H_VISIBLE)) && (tline < 11'(V_VISIBLE));
    reload   = trigger && (tline == 11'd0) && (hn == 12'd0);
    boundary = (vga_h[4:0] == 5'd0) && (vga_h < 11'(H_VISIBLE)) && (vga_v < 11'(V_VISIBLE));
  end

`ifdef FB_DOUBLE_BUFFER_EN
  // page_sel only matters at the frame reload, so a mid-frame flip cannot tear.
  assign reload_addr = BASE_ADDR + (page_sel ? 16'(PAGE_WORDS) : 16'd0);
`else
  assign reload_addr = BASE_ADDR;
`endif
  assign fetch_addr = reload ? reload_addr : fcnt_q;

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    fcnt_d         = fcnt_q;
    vid_word_d     = vid_word_q;
    underrun_d     = underrun_q;
    cpu_ack_d      = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    mem_addr_d     = mem_addr_q;
    mem_we_d       = 1'b0;
    mem_wdata_d    = mem_wdata_q;

    if (state_q == StVidRd) pending_d = 1'b0;
    if (trigger) begin
      if (pending_q) underrun_d = 1'b1;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Taking the trigger directly saves a cycle of fetch latency.
        if (pending_q || trigger) begin
          state_d    = StVidRd;
          mem_addr_d = fetch_addr;
        end else if (cpu_req && !cpu_ack_q) begin
          mem_addr_d = cpu_addr;
          if (cpu_we) begin
            state_d     = StCpuWr;
            mem_we_d    = 1'b1;
            mem_wdata_d = cpu_wdata;
          end else begin
            state_d = StCpuRd;
          end
        end
      end
      StVidRd: state_d = StVidData;
      StVidData: begin
        shadow_d       = mem_rdata;
        shadow_valid_d = 1'b1;
        fcnt_d         = fcnt_q + 16'd1;
        state_d        = StIdle;
      end
      StCpuWr: begin
        cpu_ack_d = 1'b1;
        state_d   = StIdle;
      end
      StCpuRd: state_d = StCpuData;
      StCpuData: begin
        cpu_rdata_d = mem_rdata;
        cpu_ack_d   = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reload) fcnt_d = reload_addr;

    // A word landing on the boundary edge is too late for this group.
    if (boundary) begin
      vid_word_d     = shadow_valid_q ? shadow_q : 32'd0;
      shadow_valid_d = 1'b0;
      if (!shadow_valid_q) underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pending_q      <= 1'b0;
      shadow_q       <= 32'd0;
      shadow_valid_q <= 1'b0;
      fcnt_q         <= BASE_ADDR;
      vid_word_q     <= 32'd0;
      underrun_q     <= 1'b0;
      cpu_ack_q      <= 1'b0;
      cpu_rdata_q    <= 32'd0;
      mem_addr_q     <= 16'd0;
      mem_we_q       <= 1'b0;
      mem_wdata_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      fcnt_q         <= fcnt_d;
      vid_word_q     <= vid_word_d;
      underrun_q     <= underrun_d;
      cpu_ack_q      <= cpu_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_we_q       <= mem_we_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign vid_word  = vid_word_q;
  assign underrun  = underrun_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between VGA scanout and a CPU-side requester.
- Prefetches 32-pixel 1bpp words ahead of the beam, using the VGA h/v counters, and presents the current word to the pixel shifter.
- Grants CPU reads and writes in every cycle scanout does not need the RAM.
- Sits between the VGA timing generator, the pixel output stage and the frame-buffer RAM.

Parameters:
- H_VISIBLE, 640, visible pixels per line (multiple of 32).
- H_TOTAL, 800, total clocks per line.
- V_VISIBLE, 480, visible lines.
- V_TOTAL, 525, total lines per frame.
- FETCH_LEAD, 8, clocks a fetch is triggered before its 32-pixel group starts (must be >=5).
- BASE_ADDR, 16'h0000, RAM word address of pixel (0,0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- vga_h  in  11  current horizontal count, 0..H_TOTAL-1
- vga_v  in  11  current vertical count, 0..V_TOTAL-1
- vid_word  out  32  current pixel group, bit 31 = leftmost pixel
- underrun  out  1  sticky: a scanout word was not ready in time
- cpu_req  in  1  CPU request; held with addr/we/wdata stable until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  one-cycle pulse, request complete
- cpu_rdata  out  32  read data, valid in the cpu_ack cycle
- mem_addr  out  16  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, 1-cycle latency after address issue

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - all outputs to 0;
  - FSM to IDLE;
  - fetch pending flag and shadow-valid flag cleared;
  - fetch address counter to BASE_ADDR.
- Trigger computation:
  - hn = vga_h + FETCH_LEAD. If hn >= H_TOTAL, then hn -= H_TOTAL and the target line is vga_v+1 (wrapping to 0 at V_TOTAL); otherwise the target line is vga_v.
  - A trigger fires when hn[4:0]==0, hn < H_VISIBLE and target line < V_VISIBLE.
- At a trigger with target (line 0, hn 0), the fetch address counter reloads to BASE_ADDR before the fetch. Each completed fetch increments the counter, so lines are contiguous, H_VISIBLE/32 words per line.
- A trigger sets pending. If pending is already set at a trigger, set underrun and keep a single pending request.
- FSM states: IDLE, VID_RD, VID_DATA, CPU_WR, CPU_RD, CPU_DATA.
  - IDLE: pending -> VID_RD; else cpu_req and not blocked -> CPU_WR (we=1) or CPU_RD (we=0). Scanout has strict priority.
  - VID_RD: drive mem_addr = fetch counter, clear pending -> VID_DATA.
  - VID_DATA: capture mem_rdata into shadow, set shadow-valid, increment counter -> IDLE.
  - CPU_WR: drive mem_addr/mem_we=1/mem_wdata, pulse cpu_ack -> IDLE.
  - CPU_RD: drive mem_addr -> CPU_DATA.
  - CPU_DATA: cpu_rdata <= mem_rdata, pulse cpu_ack -> IDLE.
- The CPU is blocked in the cycle after cpu_ack. The requester drops or changes cpu_req in that cycle; a held req is treated as a new request only after the gap.
- mem_we is 1 only in CPU_WR. mem_addr and mem_wdata hold their last values otherwise.
- Group boundary: when vga_h[4:0]==0, vga_h < H_VISIBLE and vga_v < V_VISIBLE, vid_word <= shadow at that edge and shadow-valid is cleared.
  - If shadow-valid was 0 at the boundary, set underrun and drive vid_word <= 0.
- Outside the visible region, vid_word holds its value and the CPU gets every slot.
- Worst-case trigger-to-shadow latency is 4 cycles (an in-flight CPU read plus the fetch), hence FETCH_LEAD >= 5.
- underrun clears only on reset.
- A reset mid-operation abandons any in-flight access with no ack. The requester must re-issue.

Optional Feature:
- Macro FB_DOUBLE_BUFFER_EN.
- Defined:
  - Adds input port page_sel (1 bit) and parameter PAGE_WORDS (default 9600).
  - At the frame reload (target line 0, group 0), the fetch counter loads BASE_ADDR + page_sel_latched*PAGE_WORDS. page_sel is sampled only at that trigger, so switching pages is tear-free.
  - CPU addressing is unaffected.
- Undefined: no page_sel port; reload is always BASE_ADDR.

Test Plan:
- Reset, then v=524, h=792 (FETCH_LEAD=8) -> mem_addr=0x0000 in VID_RD next cycle; at v=0, h=0 edge vid_word = RAM[0]; underrun=0.
- Full frame with preloaded RAM word k = k -> every visible group receives the consecutive word; last fetch address 0x257F (9599); underrun stays 0.
- CPU write addr 0x0010, data 0xDEADBEEF during vblank -> mem_we=1 one cycle later, cpu_ack pulses once; readback with we=0 returns 0xDEADBEEF in the ack cycle, 2 cycles after grant.
- cpu_req held continuously during visible line 10 -> every fetch still completes before its boundary; CPU acks interleave with a >=1 idle-cycle gap after each; underrun=0.
- Bench sets pending twice by forcing FETCH_LEAD=2 -> underrun=1, vid_word=0 at the missed boundary; only rst_n=0 clears it.
- FB_DOUBLE_BUFFER_EN defined, page_sel=1 before frame reload -> first fetch address 0x2580; toggling page_sel mid-frame has no effect until the next frame.
